// File: rtl/z_alu_issue.sv
// Issue/writeback controller for an external combinational z_ALU: one MIPS instruction
// in flight at a time. It handles register writeback, branch resolution and a
// load/store handshake to data memory.
module z_alu_issue #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ins_valid,
    output logic        ins_ready,
    input  logic [31:0] ins,
    input  logic [31:0] ins_pc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [31:0] alu_ins,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        br_valid,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        done,
    output logic        err,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);
    localparam int CW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM} state_t;

    state_t        state, state_nx;
    logic [31:0]   regs [32];
    logic [31:0]   ins_q, pc_q;
    logic [CW-1:0] wait_cnt;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        op_r, op_beq, op_bne, op_addiu, op_andi, op_lw, op_sw;
    logic        op_ok, op_mem, op_br, timeout;

    assign opcode   = ins_q[31:26];
    assign rs       = ins_q[25:21];
    assign rt       = ins_q[20:16];
    assign rd       = ins_q[15:11];
    assign imm      = ins_q[15:0];
    assign op_r     = (opcode == 6'h00);
    assign op_beq   = (opcode == 6'h04);
    assign op_bne   = (opcode == 6'h05);
    assign op_addiu = (opcode == 6'h09);
    assign op_andi  = (opcode == 6'h0C);
    assign op_lw    = (opcode == 6'h23);
    assign op_sw    = (opcode == 6'h2B);
    assign op_mem   = op_lw | op_sw;
    assign op_br    = op_beq | op_bne;
    assign op_ok    = op_r | op_br | op_addiu | op_andi | op_mem;
    assign timeout  = (wait_cnt == CW'(MEM_TIMEOUT - 1));

    assign ins_ready = (state == S_IDLE);
    assign dbg_rdata = regs[dbg_raddr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (ins_valid) state_nx = S_DECODE;
            S_DECODE: state_nx = op_ok ? S_EXEC : S_IDLE;
            S_EXEC:   state_nx = op_mem ? S_MEM : S_IDLE;
            S_MEM:    if (mem_ack || timeout) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Single register-file write port: debug preload only in IDLE, otherwise retirement.
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        case (state)
            S_IDLE: begin
                rf_we = dbg_we;
                rf_wa = dbg_addr;
                rf_wd = dbg_wdata;
            end
            S_EXEC: begin
                rf_we = op_r | op_addiu | op_andi;
                rf_wa = op_r ? rd : rt;
                rf_wd = alu_out;
            end
            S_MEM: begin
                rf_we = mem_ack & op_lw;
                rf_wa = rt;
                rf_wd = mem_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rf_wa != 5'd0) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_q     <= '0;
            pc_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_shamt <= '0;
            alu_ins   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            br_valid  <= 1'b0;
            br_taken  <= 1'b0;
            br_target <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            br_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_req  <= (state_nx == S_MEM);
            case (state)
                S_IDLE: begin
                    if (ins_valid) begin
                        ins_q <= ins;
                        pc_q  <= ins_pc;
                    end
                end
                S_DECODE: begin
                    if (op_ok) begin
                        alu_ins   <= ins_q;
                        alu_shamt <= ins_q[10:6];
                        alu_a     <= regs[rs];
                        if (op_r || op_br)          alu_b <= regs[rt];
                        else if (op_andi)           alu_b <= {16'h0000, imm};
                        else                        alu_b <= {{16{imm[15]}}, imm};
                    end else begin
                        err <= 1'b1;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (op_mem) begin
                        mem_addr  <= alu_out;
                        mem_we    <= op_sw;
                        mem_wdata <= regs[rt];
                    end else begin
                        done <= 1'b1;
                    end
                    if (op_br) begin
                        br_valid  <= 1'b1;
                        br_taken  <= op_beq ? alu_zero : ~alu_zero;
                        br_target <= pc_q + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
                    end
                end
                S_MEM: begin
                    if (mem_ack)      done <= 1'b1;
                    else if (timeout) err  <= 1'b1;
                    else              wait_cnt <= wait_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z_alu_issue.sv
// Bench for z_alu_issue: a behavioural z_ALU is attached, a vector table covers the
// ALU/branch instructions and hand sequences cover memory, timeout, bad opcode and reset.
module tb_z_alu_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins, ins_pc;
    logic [31:0] alu_a, alu_b, alu_ins, alu_out;
    logic [4:0]  alu_shamt;
    logic        alu_zero;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        br_valid, br_taken, done, err;
    logic [31:0] br_target;
    logic        dbg_we;
    logic [4:0]  dbg_addr, dbg_raddr;
    logic [31:0] dbg_wdata, dbg_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    z_alu_issue dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins(ins), .ins_pc(ins_pc), .alu_a(alu_a), .alu_b(alu_b),
        .alu_shamt(alu_shamt), .alu_ins(alu_ins), .alu_out(alu_out), .alu_zero(alu_zero),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .br_valid(br_valid), .br_taken(br_taken),
        .br_target(br_target), .done(done), .err(err), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural z_ALU
    always_comb begin
        alu_out = '0;
        case (alu_ins[31:26])
            6'h00: case (alu_ins[5:0])
                6'h21:   alu_out = alu_a + alu_b;
                6'h23:   alu_out = alu_a - alu_b;
                6'h24:   alu_out = alu_a & alu_b;
                6'h25:   alu_out = alu_a | alu_b;
                6'h00:   alu_out = alu_b << alu_shamt;
                default: alu_out = '0;
            endcase
            6'h04, 6'h05:        alu_out = alu_a - alu_b;
            6'h09, 6'h23, 6'h2B: alu_out = alu_a + alu_b;
            6'h0C:               alu_out = alu_a & alu_b;
            default:             alu_out = '0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
        dbg_raddr = a;
        #1;
        v = dbg_rdata;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        @(posedge clk); #1;
        dbg_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] pc, input bit dw,
                         input logic [4:0] da, input logic [31:0] dd);
        @(negedge clk);
        ins = w; ins_pc = pc; ins_valid = 1'b1;
        dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        chk("ready_at_offer", {31'b0, ins_ready}, 32'd1);
        @(posedge clk); #1;
        ins_valid = 1'b0;
        dbg_we = 1'b0;
    endtask

    task automatic wait_retire(output int lat, output int rdy_low, output bit gd, output bit ge,
                               output bit gb, output bit tk, output logic [31:0] tg);
        lat = 0; rdy_low = 0; gd = 0; ge = 0; gb = 0; tk = 0; tg = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (!ins_ready) rdy_low++;
            if (done || err) begin
                gd = done; ge = err; gb = br_valid; tk = br_taken; tg = br_target;
                break;
            end
        end
        if (!(gd || ge)) begin
            total++; bad++;
            $display("FAIL retire_timeout: got no done/err expected a pulse within 40 cycles");
        end
    endtask

    task automatic mem_txn(input logic [31:0] w, input int ack_at, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic e_we, input logic [31:0] e_wdata,
                           input bit poke, output int reqc, output bit gd, output bit ge,
                           output bit req_end);
        issue(w, 32'h200, 1'b0, 5'd0, 32'd0);
        reqc = 0; gd = 0; ge = 0; req_end = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            dbg_we  = 1'b0;
            if (done || err) begin
                gd = done; ge = err; req_end = mem_req;
                break;
            end
            if (mem_req) begin
                reqc++;
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
                chk("mem_wdata", mem_wdata, e_wdata);
                if (reqc == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
                if (poke && reqc == 2) begin
                    dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h0000_5555;
                end
            end
        end
        mem_ack = 1'b0;
        dbg_we  = 1'b0;
        if (!(gd || ge)) begin
            total++; bad++;
            $display("FAIL mem_timeout_bound: got no done/err expected a pulse within 60 cycles");
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [31:0] val;
        bit          is_br;
        bit          taken;
        logic [31:0] target;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, rdy_low, reqc;
        bit gd, ge, gb, tk, req_end;
        logic [31:0] tg, v, e;

        vecs[0] = '{32'h03E0F823, 32'h0,        5'd31, 32'h0FB7AFF0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{32'h00221821, 32'h0,        5'd3,  32'hAFC4BFE0, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{32'h2425FFFF, 32'h0,        5'd5,  32'h0FB7AFEF, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{32'h3046FFFF, 32'h0,        5'd6,  32'h00000FF0, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{32'h1021FFFF, 32'h100,      5'd1,  32'h0FB7AFF0, 1'b1, 1'b1, 32'h100};
        vecs[5] = '{32'h1421FFFF, 32'h100,      5'd1,  32'h0FB7AFF0, 1'b1, 1'b0, 32'h100};
        vecs[6] = '{32'h10220003, 32'hFFFFFFF0, 5'd2,  32'hA00D0FF0, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{32'h00413823, 32'h0,        5'd7,  32'h90556000, 1'b0, 1'b0, 32'h0};

        rst = 1'b1; ins_valid = 0; ins = '0; ins_pc = '0; mem_ack = 0; mem_rdata = '0;
        dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_raddr = '0;
        repeat (2) @(negedge clk);
        chk("rst_ins_ready", {31'b0, ins_ready}, 32'd1);
        chk("rst_done_err_br", {29'b0, done, err, br_valid}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        preload(5'd31, 32'h0FB7AFF0);
        preload(5'd0,  32'h00000005);
        preload(5'd1,  32'h0FB7AFF0);
        preload(5'd2,  32'hA00D0FF0);
        @(negedge clk);
        rd_reg(5'd0, v);
        chk("r0_after_dbg", v, 32'd0);

        foreach (vecs[k]) begin
            issue(vecs[k].ins, vecs[k].pc, 1'b0, 5'd0, 32'd0);
            exp_q.push_back(vecs[k].val);
            wait_retire(lat, rdy_low, gd, ge, gb, tk, tg);
            chk($sformatf("v%0d_latency", k), lat, 3);
            chk($sformatf("v%0d_ready_low", k), rdy_low, 2);
            chk($sformatf("v%0d_done_err", k), {30'b0, gd, ge}, 32'd2);
            chk($sformatf("v%0d_br_valid", k), {31'b0, gb}, {31'b0, vecs[k].is_br});
            if (vecs[k].is_br) begin
                chk($sformatf("v%0d_br_taken", k), {31'b0, tk}, {31'b0, vecs[k].taken});
                chk($sformatf("v%0d_br_target", k), tg, vecs[k].target);
            end
            rd_reg(vecs[k].dst, v);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("v%0d_reg", k), v, e);
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", k), {31'b0, done}, 32'd0);
        end
        rd_reg(5'd0, v);
        chk("r0_still_zero", v, 32'd0);

        // dbg write in the accept cycle is visible to DECODE
        issue(32'h00294021, 32'h0, 1'b1, 5'd9, 32'd1);
        wait_retire(lat, rdy_low, gd, ge, gb, tk, tg);
        rd_reg(5'd8, v);
        chk("dbg_same_cycle_r8", v, 32'h0FB7AFF1);
        rd_reg(5'd9, v);
        chk("dbg_same_cycle_r9", v, 32'd1);

        // store acked on the 5th request cycle
        mem_txn(32'hAC220004, 5, 32'd0, 32'h0FB7AFF4, 1'b1, 32'hA00D0FF0, 1'b0,
                reqc, gd, ge, req_end);
        chk("sw_req_cycles", reqc, 5);
        chk("sw_done_err", {30'b0, gd, ge}, 32'd2);
        rd_reg(5'd2, v);
        chk("sw_r2_kept", v, 32'hA00D0FF0);

        // load with no ack; a dbg write attempted during MEM must be ignored
        mem_txn(32'h8C240000, 0, 32'd0, 32'h0FB7AFF0, 1'b0, 32'd0, 1'b1,
                reqc, gd, ge, req_end);
        chk("lw_to_req_cycles", reqc, 16);
        chk("lw_to_done_err", {30'b0, gd, ge}, 32'd1);
        chk("lw_to_req_low", {31'b0, req_end}, 32'd0);
        chk("lw_to_idle", {31'b0, ins_ready}, 32'd1);
        rd_reg(5'd4, v);
        chk("lw_to_r4", v, 32'd0);

        // load acked on the 3rd request cycle
        mem_txn(32'h8C240000, 3, 32'h13579BDF, 32'h0FB7AFF0, 1'b0, 32'd0, 1'b0,
                reqc, gd, ge, req_end);
        chk("lw_req_cycles", reqc, 3);
        chk("lw_done_err", {30'b0, gd, ge}, 32'd2);
        rd_reg(5'd4, v);
        chk("lw_r4", v, 32'h13579BDF);

        // unsupported opcode
        issue(32'hFC000000, 32'h0, 1'b0, 5'd0, 32'd0);
        wait_retire(lat, rdy_low, gd, ge, gb, tk, tg);
        chk("badop_latency", lat, 2);
        chk("badop_done_err", {30'b0, gd, ge}, 32'd1);
        rd_reg(5'd3, v);
        chk("badop_r3_kept", v, 32'hAFC4BFE0);
        @(negedge clk);
        chk("badop_err_one_cycle", {31'b0, err}, 32'd0);

        // reset asserted during MEM of a load
        issue(32'h8C240000, 32'h0, 1'b0, 5'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rstmem_req_before", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmem_req", {31'b0, mem_req}, 32'd0);
        chk("rstmem_ready", {31'b0, ins_ready}, 32'd1);
        chk("rstmem_mem_addr", mem_addr, 32'd0);
        chk("rstmem_alu_ins", alu_ins, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmem_ready_after", {31'b0, ins_ready}, 32'd1);
        chk("rstmem_pulses_after", {28'b0, done, err, br_valid, mem_req}, 32'd0);
        rd_reg(5'd1, v);
        chk("rstmem_r1_zero", v, 32'd0);
        rd_reg(5'd4, v);
        chk("rstmem_r4_zero", v, 32'd0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/z_alu_issue.md
Name: z_alu_issue

Overview:
- Multi-cycle issue/writeback controller that drives the z_ALU and consumes its results for one instruction at a time.
- Accepts 32-bit MIPS instruction words over a valid/ready handshake and holds the 32x32 register file.
- Drives a_in/b_in/shamt_in/ins_in to the external z_ALU, then captures out/zero.
- Performs register writeback, branch resolution, and a load/store handshake to data memory.

Parameters:
- RESET_PC_UNUSED, none: the block holds no PC; the instruction's PC arrives on ins_pc.
- MEM_TIMEOUT, 16: cycles to wait for mem_ack before aborting with err.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- ins_valid  in  1  instruction offered
- ins_ready  out  1  controller can accept an instruction (IDLE only)
- ins  in  32  instruction word
- ins_pc  in  32  address of ins
- alu_a  out  32  drives z_ALU a_in
- alu_b  out  32  drives z_ALU b_in
- alu_shamt  out  5  drives z_ALU shamt_in
- alu_ins  out  32  drives z_ALU ins_in
- alu_out  in  32  z_ALU out
- alu_zero  in  1  z_ALU zero
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store (sw), 0 = load (lw)
- mem_addr  out  32  effective address
- mem_wdata  out  32  store data, R[rt]
- mem_ack  in  1  one-cycle acknowledge
- mem_rdata  in  32  load data, valid with mem_ack
- br_valid  out  1  one-cycle pulse, branch resolved
- br_taken  out  1  branch outcome
- br_target  out  32  ins_pc+4+(sext(imm)<<2)
- done  out  1  one-cycle pulse, instruction retired
- err  out  1  one-cycle pulse, unsupported opcode or memory timeout
- dbg_we  in  1  register preload write (honoured in IDLE only)
- dbg_addr  in  5  preload register index
- dbg_wdata  in  32  preload data
- dbg_raddr  in  5  debug read index
- dbg_rdata  out  32  combinational R[dbg_raddr]

Behaviour:
- Reset: the register file is all zeros. Every output is 0 except ins_ready=1. State is IDLE. Reset asserted mid-instruction aborts it with no writeback and no pulses.
- R0 reads 0 always. Writes to R0 (writeback or dbg) are discarded.
- IDLE:
  - ins_ready=1.
  - On ins_valid&&ins_ready, latch ins and ins_pc, then go to DECODE.
  - dbg_we writes the register in IDLE. dbg_we is ignored in any other state.
  - If ins_valid and dbg_we arrive in the same cycle, both occur. The dbg write lands first, and DECODE sees the new value.
- DECODE:
  - Register the ALU drives.
  - alu_ins = latched ins.
  - alu_shamt = ins[10:6].
  - alu_a = R[rs].
  - alu_b selection:
    - opcode 0x00/0x04/0x05 (R-type, beq, bne): R[rt].
    - 0x09/0x23/0x2B (addiu, lw, sw): sign-extended ins[15:0].
    - 0x0C (andi): zero-extended ins[15:0].
  - Any other opcode: pulse err and return to IDLE with no writes.
  - Next state: EXEC.
- EXEC: the ALU is combinational, so sample alu_out and alu_zero this cycle.
  - R-type: R[rd] <- alu_out, pulse done, go to IDLE.
  - addiu/andi: R[rt] <- alu_out, pulse done, go to IDLE.
  - beq: br_valid=1, br_taken=alu_zero.
  - bne: br_valid=1, br_taken=!alu_zero.
  - beq/bne: br_target is computed with 32-bit wraparound. Pulse done the same cycle, then go to IDLE.
  - lw/sw: mem_addr=alu_out, mem_we=(opcode==0x2B), mem_wdata=R[rt]. Go to MEM.
- MEM:
  - mem_req=1, with address and data held stable until mem_ack.
  - On mem_ack, go to IDLE and pulse done:
    - lw: R[rt] <- mem_rdata.
    - sw: no register write.
  - The wait counter increments each cycle without ack. When it reaches MEM_TIMEOUT, drop mem_req, pulse err (not done), and return to IDLE.
  - mem_ack received outside MEM is ignored.
- ALU drive registers hold their last values between instructions.
- Latency, accept to done:
  - ALU/branch instructions: 3 cycles (IDLE, DECODE, EXEC).
  - lw/sw: 3 cycles + memory wait.
- ins_ready is low from the accept cycle until the cycle the state re-enters IDLE.

Test Plan:
- Preload R31=0x0FB7AFF0 and R0 attempt=0x5 via dbg. Issue subu (0x03E0F823) with the z_ALU attached. Required: done 3 cycles after accept, R31=0x0FB7AFF0 (rs=31, rt=0), dbg_rdata(0)=0.
- Preload R1=0x0FB7AFF0, R2=0xA00D0FF0. Issue addu rd=3 (0x00221821). Required: R3=0xAFC4BFE0, no err, ins_ready low exactly for accept..EXEC.
- beq R1,R1,imm=0xFFFF with ins_pc=0x100. Required: br_valid pulse, br_taken=1, br_target=0x100. Then bne with the same operands: br_taken=0.
- sw R2 to 4(R1). Required: mem_req high with mem_we=1, mem_addr=0x0FB7AFF4, mem_wdata=0xA00D0FF0, held for 5 cycles until mem_ack, then done.
- lw R4,0(R1) with no mem_ack. Required: err after 16 MEM cycles, R4 unchanged, mem_req low, back in IDLE. Then issue opcode 0x3F: err pulse one cycle after DECODE, no register change.
- Assert rst during MEM of an lw. Required: immediate return of all outputs to reset values, registers zeroed, ins_ready=1 on the next cycle after rst drops.
